// File: rtl/tt_bist_harness.sv
// On-chip self-test harness: LFSR pattern source, MISR response compactor, signature compare.
// Optional serial signature readout in DONE is enabled by defining BIST_SIG_SHIFT_EN.
module tt_bist_harness #(
  parameter int unsigned            IN_W      = 8,
  parameter int unsigned            OUT_W     = 8,
  parameter int unsigned            NUM_PAT   = 256,
  parameter int unsigned            DUT_LAT   = 1,
  parameter logic [IN_W-1:0]        SEED      = IN_W'(1),
  parameter logic [IN_W-1:0]        LFSR_TAPS = IN_W'(8'hB8),
  parameter logic [OUT_W-1:0]       MISR_TAPS = OUT_W'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  pat_out,
  output logic             pat_valid,
  input  logic [OUT_W-1:0] resp_in,
  input  logic [OUT_W-1:0] exp_sig,
  output logic [OUT_W-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef BIST_SIG_SHIFT_EN
  ,
  input  logic             sig_shift,
  output logic             sig_sdo
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_PAT + 1);
  localparam int unsigned LAT_W = (DUT_LAT > 0) ? DUT_LAT : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [OUT_W-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] dly_q, dly_d;
  logic             pass_q, pass_d;

  logic launch;
  logic last_pat;
  logic drain_empty;
  logic cap;

  assign launch   = start & ~abort &
                    ((state_q == S_IDLE) | (state_q == S_DONE));
  assign last_pat = (cnt_q == CNT_W'(NUM_PAT - 1));

  // Delay line drains once its next value holds no live pattern.
  assign drain_empty = (LAT_W'({dly_q, 1'b0}) == '0);

  generate
    if (DUT_LAT == 0) begin : g_cap_comb
      assign cap = (state_q == S_RUN);
    end else begin : g_cap_dly
      assign cap = dly_q[LAT_W-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (last_pat) state_d = (DUT_LAT == 0) ? S_CMP : S_DRAIN;
      end
      S_DRAIN: if (drain_empty) state_d = S_CMP;
      S_CMP: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    cnt_d  = cnt_q;
    dly_d  = LAT_W'({dly_q, pat_valid});
    pass_d = pass_q;
    if (pat_valid) begin
      lfsr_d = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      cnt_d  = cnt_q + CNT_W'(1);
    end
    if (cap) misr_d = {misr_q[OUT_W-2:0], ^(misr_q & MISR_TAPS)} ^ resp_in;
`ifdef BIST_SIG_SHIFT_EN
    if ((state_q == S_DONE) && sig_shift) misr_d = {misr_q[OUT_W-2:0], 1'b0};
`endif
    if (state_q == S_CMP) pass_d = (misr_q == exp_sig);
    if (launch) begin
      lfsr_d = SEED;
      misr_d = '0;
      cnt_d  = '0;
      dly_d  = '0;
      pass_d = 1'b0;
    end
    // Abort keeps the signature visible for post-mortem inspection.
    if (abort) begin
      lfsr_d = SEED;
      misr_d = misr_q;
      cnt_d  = '0;
      dly_d  = '0;
      pass_d = 1'b0;
    end
  end

  always_comb begin
    pat_out   = lfsr_q;
    pat_valid = (state_q == S_RUN);
    busy      = (state_q == S_RUN) | (state_q == S_DRAIN) |
                (state_q == S_CMP);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    signature = misr_q;
`ifdef BIST_SIG_SHIFT_EN
    sig_sdo   = (state_q == S_DONE) ? misr_q[OUT_W-1] : 1'b0;
`endif
  end

endmodule
